// File: rtl/fp24_pkg.sv
// fp24 scalar/vec3 types, vec3 ALU opcodes and truncating fp24 add/mul primitives.
// fp24 = {sign, 7-bit exponent (bias 63), 16-bit fraction}; zero and denormals collapse to +0.
package fp24_pkg;
  typedef logic [23:0] fp24;
  typedef struct packed { fp24 x; fp24 y; fp24 z; } fp24_vec3;
  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_SCALE = 3'd3,
    OP_DOT   = 3'd4
  } vec3_op_t;

  localparam int FP24_VEC3_ALU_LAT = 2;
  localparam int FP24_BIAS         = 63;

  function automatic fp24 fp24_pack(logic s, int e, logic [15:0] f);
    if (e <= 0) return 24'h0;
    if (e > 127) return {s, 7'h7f, 16'hffff};
    return {s, 7'(e), f};
  endfunction

  function automatic fp24 fp24_mul(fp24 a, fp24 b);
    logic [33:0] p;
    int e;
    if (a[22:16] == 7'd0 || b[22:16] == 7'd0) return 24'h0;
    p = {17'd0, 1'b1, a[15:0]} * {17'd0, 1'b1, b[15:0]};
    e = int'(a[22:16]) + int'(b[22:16]) - FP24_BIAS;
    if (p[33]) return fp24_pack(a[23] ^ b[23], e + 1, p[32:17]);
    return fp24_pack(a[23] ^ b[23], e, p[31:16]);
  endfunction

  // Three guard bits below the fraction keep cancellation exact for nearby exponents.
  function automatic fp24 fp24_add(fp24 a, fp24 b);
    fp24 big, sml;
    logic [20:0] mb, ms, sum;
    int e, d;
    if (a[22:0] >= b[22:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    if (big[22:16] == 7'd0) return 24'h0;
    if (sml[22:16] == 7'd0) return big;
    e  = int'(big[22:16]);
    d  = e - int'(sml[22:16]);
    mb = {2'b01, big[15:0], 3'b000};
    ms = (d > 20) ? 21'd0 : ({2'b01, sml[15:0], 3'b000} >> d);
    if (big[23] == sml[23]) begin
      sum = mb + ms;
      if (sum[20]) begin sum = sum >> 1; e = e + 1; end
    end else begin
      sum = mb - ms;
      if (sum == 21'd0) return 24'h0;
      for (int i = 0; i < 19; i++)
        if (!sum[19]) begin sum = sum << 1; e = e - 1; end
    end
    return fp24_pack(big[23], e, sum[18:3]);
  endfunction
endpackage

// File: rtl/fp24_vec3_alu.sv
// Fixed-latency fp24 vec3 datapath: every op takes LAT cycles, so tagged results never collide.
module fp24_vec3_alu
  import fp24_pkg::*;
#(
  parameter int LAT   = FP24_VEC3_ALU_LAT,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_op,
  input  fp24_vec3         in_a,
  input  fp24_vec3         in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output fp24_vec3         out_res,
  output logic             busy
);
  logic [LAT-1:0]   v;
  logic [TAG_W-1:0] tag [LAT];
  logic [2:0]       op0;
  fp24_vec3         r0;
  fp24              pxy, pz;
  fp24_vec3         res [1:LAT-1];
  fp24_vec3         prod, r_c;

  always_comb begin
    prod.x = fp24_mul(in_a.x, in_b.x);
    prod.y = fp24_mul(in_a.y, in_b.y);
    prod.z = fp24_mul(in_a.z, in_b.z);
    r_c    = '0;
    case (in_op)
      OP_ADD:   r_c = {fp24_add(in_a.x, in_b.x), fp24_add(in_a.y, in_b.y), fp24_add(in_a.z, in_b.z)};
      OP_SUB:   r_c = {fp24_add(in_a.x, in_b.x ^ 24'h800000), fp24_add(in_a.y, in_b.y ^ 24'h800000),
                       fp24_add(in_a.z, in_b.z ^ 24'h800000)};
      OP_MUL:   r_c = prod;
      OP_SCALE: r_c = {fp24_mul(in_a.x, in_b.x), fp24_mul(in_a.y, in_b.x), fp24_mul(in_a.z, in_b.x)};
      default:  r_c = '0;
    endcase
  end

  // Data registers load only with a valid op so the output holds its last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      op0 <= '0;
      r0  <= '0;
      pxy <= '0;
      pz  <= '0;
      for (int k = 0; k < LAT; k++) tag[k] <= '0;
      for (int k = 1; k < LAT; k++) res[k] <= '0;
    end else begin
      v      <= {v[LAT-2:0], in_valid};
      tag[0] <= in_tag;
      for (int k = 1; k < LAT; k++) tag[k] <= tag[k-1];
      if (in_valid) begin
        op0 <= in_op;
        r0  <= r_c;
        pxy <= fp24_add(prod.x, prod.y);
        pz  <= prod.z;
      end
      if (v[0]) res[1] <= (op0 == OP_DOT) ? {fp24_add(pxy, pz), 24'h0, 24'h0} : r0;
      for (int k = 2; k < LAT; k++)
        if (v[k-1]) res[k] <= res[k-1];
    end
  end

  assign out_valid = v[LAT-1];
  assign out_tag   = tag[LAT-1];
  assign out_res   = res[LAT-1];
  assign busy      = |v;
endmodule

// File: rtl/fp24_vec3_alu_arbiter.sv
// Round-robin sharing of one fp24 vec3 ALU among NUM_REQ requesters; results return tagged by id.
module fp24_vec3_alu_arbiter
  import fp24_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LAT     = FP24_VEC3_ALU_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][2:0]  req_op,
  input  logic [NUM_REQ-1:0][71:0] req_a,
  input  logic [NUM_REQ-1:0][71:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [71:0]              resp_data,
  output logic                     busy
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] rr_ptr, gnt_idx, alu_tag;
  logic          gnt_any, alu_valid;
  fp24_vec3      alu_res;

  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!gnt_any && req_valid[PW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any && !rst) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)          rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= PW'((int'(gnt_idx) + 1) % NUM_REQ);
  end

  fp24_vec3_alu #(.LAT(LAT), .TAG_W(PW)) u_alu (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (gnt_any && !rst),
    .in_op     (req_op[gnt_idx]),
    .in_a      (req_a[gnt_idx]),
    .in_b      (req_b[gnt_idx]),
    .in_tag    (gnt_idx),
    .out_valid (alu_valid),
    .out_tag   (alu_tag),
    .out_res   (alu_res),
    .busy      (busy)
  );

  always_comb begin
    resp_valid = '0;
    if (alu_valid) resp_valid[alu_tag] = 1'b1;
  end

  assign resp_data = alu_res;
endmodule

// File: tb/tb_fp24_vec3_alu_arbiter.sv
// Scoreboard bench: real-arithmetic reference model and round-robin grant model vs the arbiter.
module tb_fp24_vec3_alu_arbiter;
  localparam int NR = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NR-1:0]       req_valid, req_ready, resp_valid;
  logic [NR-1:0][2:0]  req_op;
  logic [NR-1:0][71:0] req_a, req_b;
  logic [71:0]         resp_data;
  logic                busy;

  fp24_vec3_alu_arbiter #(.NUM_REQ(NR), .LAT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int op; real a0, a1, a2, b0, b1, b2; } op_t;
  typedef struct { int id; logic [71:0] data; int cyc; } exp_t;

  op_t  pend [NR][$];
  op_t  cur  [NR];
  bit   pres [NR];
  exp_t sb [$];
  int   cyc = 0, rr = 0, n_cmp = 0, n_bad = 0;
  logic rst_next = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      sb.delete();
      rr = 0;
    end
  end

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] r2f(real v);
    logic s;
    int   e;
    real  m;
    if (v == 0.0) return 24'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 63;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 7'(e), 16'($rtoi((m - 1.0) * 65536.0))};
  endfunction

  function automatic logic [71:0] model(op_t t);
    real r0 = 0.0, r1 = 0.0, r2 = 0.0;
    case (t.op)
      0: begin r0 = t.a0 + t.b0; r1 = t.a1 + t.b1; r2 = t.a2 + t.b2; end
      1: begin r0 = t.a0 - t.b0; r1 = t.a1 - t.b1; r2 = t.a2 - t.b2; end
      2: begin r0 = t.a0 * t.b0; r1 = t.a1 * t.b1; r2 = t.a2 * t.b2; end
      3: begin r0 = t.a0 * t.b0; r1 = t.a1 * t.b0; r2 = t.a2 * t.b0; end
      4: r0 = t.a0 * t.b0 + t.a1 * t.b1 + t.a2 * t.b2;
      default: ;
    endcase
    return {r2f(r0), r2f(r1), r2f(r2)};
  endfunction

  function automatic real rv();
    return real'(int'($urandom_range(0, 128)) - 64) / 4.0;
  endfunction

  function automatic op_t mk(int op, real a0, real a1, real a2, real b0, real b1, real b2);
    op_t t;
    t.op = op; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.b0 = b0; t.b1 = b1; t.b2 = b2;
    return t;
  endfunction

  function automatic op_t rop(int op);
    return mk(op, rv(), rv(), rv(), rv(), rv(), rv());
  endfunction

  function automatic int work();
    int w = sb.size();
    for (int i = 0; i < NR; i++) w += pend[i].size() + int'(pres[i]);
    return w;
  endfunction

  // One cycle of stimulus: drive at negedge, then predict and check the grant before posedge.
  task automatic step();
    int g;
    @(negedge clk);
    rst = rst_next;
    for (int i = 0; i < NR; i++) begin
      if (!pres[i] && pend[i].size() > 0) begin
        cur[i]  = pend[i].pop_front();
        pres[i] = 1'b1;
      end
      req_valid[i] = pres[i];
      if (pres[i]) begin
        req_op[i] = 3'(cur[i].op);
        req_a[i]  = {r2f(cur[i].a0), r2f(cur[i].a1), r2f(cur[i].a2)};
        req_b[i]  = {r2f(cur[i].b0), r2f(cur[i].b1), r2f(cur[i].b2)};
      end else begin
        req_op[i] = 3'($urandom_range(0, 7));
        req_a[i]  = 72'({$urandom, $urandom, $urandom});
        req_b[i]  = 72'({$urandom, $urandom, $urandom});
      end
    end
    #1;
    g = -1;
    if (!rst)
      for (int k = 0; k < NR; k++)
        if (g < 0 && pres[(rr + k) % NR]) g = (rr + k) % NR;
    chk("grant", 72'(req_ready), (g < 0) ? 72'd0 : (72'd1 << g));
    if (g >= 0) begin
      sb.push_back('{g, model(cur[g]), cyc});
      pres[g] = 1'b0;
      rr      = (g + 1) % NR;
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    while (work() > 0 && n < 300) begin step(); n++; end
    chk({"drain ", name}, 72'(work()), 72'd0);
  endtask

  initial begin : monitor
    exp_t e;
    bit   eb;
    forever begin
      @(negedge clk);
      eb = 1'b0;
      foreach (sb[k]) if ((cyc - sb[k].cyc) inside {1, 2}) eb = 1'b1;
      chk("busy", 72'(busy), 72'(eb));
      if (resp_valid != '0) begin
        if (sb.size() == 0) chk("resp_spurious", 72'(resp_valid), 72'd0);
        else begin
          e = sb.pop_front();
          chk("resp_id", 72'(resp_valid), 72'd1 << e.id);
          chk("resp_data", resp_data, e.data);
          chk("resp_latency", 72'(cyc - e.cyc), 72'd2);
        end
      end else if (sb.size() > 0 && cyc - sb[0].cyc >= 2) begin
        e = sb.pop_front();
        chk("resp_missing", 72'(resp_valid), 72'd1 << e.id);
      end
    end
  end

  initial begin
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < NR; i++) pres[i] = 1'b0;

    // All four requesters hold ops from reset onward; grants must rotate 0,1,2,3,...
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 3; j++) pend[i].push_back(rop($urandom_range(0, 4)));
    rst_next = 1'b1;
    repeat (3) step();
    chk("rst_resp_valid", 72'(resp_valid), 72'd0);
    chk("rst_resp_data", resp_data, 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    rst_next = 1'b0;
    drain("rotation");

    pend[0].push_back(mk(0, 1.0, 2.0, 3.0, 0.5, 0.5, 0.5));
    drain("single_add");

    pend[2].push_back(mk(4, 1.0, 2.0, 3.0, 4.0, 5.0, 6.0));
    pend[1].push_back(mk(3, 1.0, -2.0, 4.0, 0.5, 7.0, 9.0));
    pend[3].push_back(mk(1, 1.0, 1.0, 1.0, 2.0, 0.0, 1.0));
    drain("dot_scale_sub");

    pend[0].push_back(mk(2, 1.5, -2.0, 3.0, 2.0, 4.0, -0.25));
    pend[0].push_back(mk(4, 1.0, 2.0, 3.0, 4.0, 5.0, 6.0));
    pend[0].push_back(mk(0, -1.0, 2.25, 8.0, 1.0, 0.75, -8.0));
    drain("back_to_back");

    // Park rr at 2, then req1 and req3 compete: req3 wins first.
    pend[1].push_back(rop(0));
    drain("rr_setup");
    pend[1].push_back(rop(2));
    pend[3].push_back(rop(1));
    step();
    chk("rr_skip_grant", 72'(req_ready), 72'b1000);
    drain("rr_wrap");

    // Reset with two ops in flight: the older one emerges, the younger is dropped.
    pend[0].push_back(rop(0));
    pend[1].push_back(rop(4));
    step();
    step();
    rst_next = 1'b1;
    step();
    step();
    chk("midrst_busy", 72'(busy), 72'd0);
    chk("midrst_resp_valid", 72'(resp_valid), 72'd0);
    pend[3].push_back(rop(3));
    pend[2].push_back(rop(2));
    step();
    rst_next = 1'b0;
    step();
    chk("post_rst_grant", 72'(req_ready), 72'b0100);
    drain("post_reset");

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (pend[i].size() == 0 && $urandom_range(0, 3) != 0)
          pend[i].push_back(rop($urandom_range(0, 7)));
      step();
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
